// File: rtl/uart_pkg.sv
// Shared constants for the UART bridge, transceiver and interface: register bit indices,
// bus select codes, drain FSM encoding and the CPU bus request bundle.
package uart_pkg;
   localparam int STAT_RX_NEMPTY = 0;
   localparam int STAT_TX_NFULL  = 1;
   localparam int STAT_TX_IDLE   = 2;
   localparam int STAT_OVR       = 3;
   localparam int STAT_RX_IE     = 4;
   localparam int STAT_TX_IE     = 5;

   localparam int CTRL_RX_FLUSH  = 0;
   localparam int CTRL_TX_FLUSH  = 1;
   localparam int CTRL_RX_IE     = 2;
   localparam int CTRL_TX_IE     = 3;

   localparam logic RS_CTRL = 1'b0;
   localparam logic RS_DATA = 1'b1;

   typedef enum logic [1:0] {DRN_IDLE, DRN_START, DRN_BUSY, DRN_GAP} drain_state_t;

   typedef struct packed {
      logic       cs;
      logic       rs;
      logic       we;
      logic [7:0] din;
   } bus_req_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with AW+1 bit wrap pointers and a flush.
// A push while full is accepted when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   input  logic          flush,
   output logic          full,
   output logic          empty
);
   logic [DW-1:0] mem [2**AW];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU register bridge feeding the UART transceiver through TX/RX FIFOs.
// Define UART_FIFO_IRQ_EN to add the irq output and the rx_ie/tx_ie control bits.
module uart_fifo_bridge
   import uart_pkg::*;
#(
   parameter int TX_AW = 4,
   parameter int RX_AW = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       rs,
   input  logic       we,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       tx_start,
   output logic [7:0] tx_byte,
   input  logic       tx_busy,
   input  logic [7:0] rx_byte,
   input  logic       rx_ready
`ifdef UART_FIFO_IRQ_EN
   ,
   output logic       irq
`endif
);
   bus_req_t     req;
   logic         stat_rd, data_rd, data_wr, ctrl_wr;
   logic         rx_ready_q, rx_rise, overrun, ovr;
   logic         rx_full, rx_empty, rx_pop, rx_flush;
   logic         tx_full, tx_empty, tx_pop, tx_flush, tx_idle;
   logic [7:0]   rx_head, tx_head, status;
   drain_state_t state;
   logic         gap_cnt;

   assign req     = '{cs: cs, rs: rs, we: we, din: din};
   assign stat_rd = req.cs & ~req.we & (req.rs == RS_CTRL);
   assign data_rd = req.cs & ~req.we & (req.rs == RS_DATA);
   assign data_wr = req.cs &  req.we & (req.rs == RS_DATA);
   assign ctrl_wr = req.cs &  req.we & (req.rs == RS_CTRL);

   assign rx_rise  = rx_ready & ~rx_ready_q;
   assign rx_pop   = data_rd & ~rx_empty;
   assign rx_flush = ctrl_wr & req.din[CTRL_RX_FLUSH];
   assign overrun  = rx_rise & rx_full & ~rx_pop;
   assign tx_flush = ctrl_wr & req.din[CTRL_TX_FLUSH];
   // Never launch a byte that a same-cycle flush is discarding.
   assign tx_pop   = (state == DRN_IDLE) & ~tx_empty & ~tx_busy & ~tx_flush;
   assign tx_idle  = tx_empty & (state == DRN_IDLE) & ~tx_busy;

   uart_sync_fifo #(.DW(8), .AW(TX_AW)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(data_wr), .din(req.din), .pop(tx_pop),
      .dout(tx_head), .flush(tx_flush), .full(tx_full), .empty(tx_empty)
   );

   uart_sync_fifo #(.DW(8), .AW(RX_AW)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_rise), .din(rx_byte), .pop(rx_pop),
      .dout(rx_head), .flush(rx_flush), .full(rx_full), .empty(rx_empty)
   );

`ifdef UART_FIFO_IRQ_EN
   logic rx_ie, tx_ie;
   logic unused_din;
   assign unused_din = ^req.din[7:4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_ie <= 1'b0;
         tx_ie <= 1'b0;
         irq   <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            rx_ie <= req.din[CTRL_RX_IE];
            tx_ie <= req.din[CTRL_TX_IE];
         end
         irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty);
      end
   end
`else
   logic unused_din;
   assign unused_din = ^req.din[7:2];
`endif

   always_comb begin
      status                 = '0;
      status[STAT_RX_NEMPTY] = ~rx_empty;
      status[STAT_TX_NFULL]  = ~tx_full;
      status[STAT_TX_IDLE]   = tx_idle;
      status[STAT_OVR]       = ovr;
`ifdef UART_FIFO_IRQ_EN
      status[STAT_RX_IE]     = rx_ie;
      status[STAT_TX_IE]     = tx_ie;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_ready_q <= 1'b0;
         ovr        <= 1'b0;
         dout       <= 8'h00;
      end else begin
         rx_ready_q <= rx_ready;
         // An overrun in the same cycle as a status read must stay visible.
         if (rx_flush)     ovr <= 1'b0;
         else if (overrun) ovr <= 1'b1;
         else if (stat_rd) ovr <= 1'b0;
         if (stat_rd)      dout <= status;
         else if (data_rd) dout <= rx_empty ? 8'h00 : rx_head;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= DRN_IDLE;
         tx_start <= 1'b0;
         tx_byte  <= 8'h00;
         gap_cnt  <= 1'b0;
      end else begin
         case (state)
            DRN_IDLE: if (tx_pop) begin
               tx_byte  <= tx_head;
               tx_start <= 1'b1;
               state    <= DRN_START;
            end
            DRN_START: if (tx_busy) begin
               tx_start <= 1'b0;
               state    <= DRN_BUSY;
            end
            DRN_BUSY: if (!tx_busy) begin
               gap_cnt <= 1'b0;
               state   <= DRN_GAP;
            end
            // Two low cycles so the transceiver always sees a fresh tx_start edge.
            DRN_GAP: begin
               gap_cnt <= 1'b1;
               if (gap_cnt) state <= DRN_IDLE;
            end
            default: state <= DRN_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: behavioural transceiver plus queue-based reference model.
module tb_uart_fifo_bridge;
   logic       clk = 0, reset = 1, cs = 0, rs = 0, we = 0;
   logic [7:0] din = 0, dout, tx_byte;
   logic       tx_start, tx_busy;
   logic [7:0] rx_byte = 0;
   logic       rx_ready = 0;
`ifdef UART_FIFO_IRQ_EN
   logic       irq;
`endif
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   uart_fifo_bridge dut (
      .clk(clk), .reset(reset), .cs(cs), .rs(rs), .we(we), .din(din), .dout(dout),
      .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy),
      .rx_byte(rx_byte), .rx_ready(rx_ready)
`ifdef UART_FIFO_IRQ_EN
      , .irq(irq)
`endif
   );

   // Transceiver model: tx_start must be seen for 3 cycles, then a fixed-length busy frame.
   localparam int FRAME = 12;
   logic       busy_m = 0, stall = 0;
   int         det = 0, bcnt = 0, stab_err = 0;
   logic [7:0] cur = 0;
   logic [7:0] sent[$];
   assign tx_busy = busy_m | stall;

   always @(posedge clk) begin
      if (!busy_m) begin
         if (tx_start) begin
            if (det == 2) begin busy_m <= 1; cur <= tx_byte; bcnt <= 0; det <= 0; end
            else det <= det + 1;
         end else det <= 0;
      end else begin
         if (tx_byte !== cur) stab_err <= stab_err + 1;
         if (bcnt == FRAME) begin busy_m <= 0; sent.push_back(cur); end
         else bcnt <= bcnt + 1;
      end
   end

   // Reference model state
   logic [7:0] rxq[$], txq[$];
   logic       m_ovr = 0;

   function automatic logic [7:0] exp_stat(input logic o, input int rxn, input int txn, input logic busy);
      return {4'b0, o, (txn == 0 && !busy), (txn < 16), (rxn > 0)};
   endfunction

   task automatic access(input logic w, input logic r, input logic [7:0] d, output logic [7:0] q);
      @(negedge clk); cs = 1; we = w; rs = r; din = d;
      @(negedge clk); cs = 0; we = 0; q = dout;
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      @(negedge clk); rx_ready = 1; rx_byte = b;
      if (rxq.size() < 16) rxq.push_back(b); else m_ovr = 1;
      @(negedge clk); rx_ready = 0;
   endtask

   task automatic test_reset();
      logic [7:0] q;
      reset = 1;
      repeat (2) @(negedge clk);
      total++; if (dout !== 8'h00)   begin bad++; $display("FAIL rst_dout got=%h exp=00", dout); end
      total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
      total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte got=%h exp=00", tx_byte); end
      reset = 0;
      access(0, 0, 8'h00, q);
      total++; if (q !== exp_stat(0, 0, 0, 0)) begin bad++; $display("FAIL rst_status got=%h exp=%h", q, exp_stat(0, 0, 0, 0)); end
   endtask

   task automatic test_tx_stream();
      int n, base, k;
      n = $urandom_range(3, 6);
      base = sent.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 1) begin total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL tx_lat_early got=%b exp=0", tx_start); end end
         if (i == 2) begin total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL tx_lat_2 got=%b exp=1", tx_start); end end
         cs = 1; we = 1; rs = 1; din = 8'($urandom);
         txq.push_back(din);
      end
      @(negedge clk); cs = 0; we = 0;
      k = 0;
      while (sent.size() < base + n && k < 3000) begin @(negedge clk); k++; end
      total++; if (sent.size() != base + n) begin bad++; $display("FAIL tx_stream_timeout got=%0d exp=%0d", sent.size() - base, n); end
      for (int i = 0; i < n && base + i < sent.size(); i++) begin
         total++; if (sent[base+i] !== txq[i]) begin bad++; $display("FAIL tx_stream_byte%0d got=%h exp=%h", i, sent[base+i], txq[i]); end
      end
      total++; if (stab_err != 0) begin bad++; $display("FAIL tx_byte_stable got=%0d exp=0", stab_err); end
      txq.delete();
      repeat (6) @(negedge clk);
   endtask

   task automatic test_tx_full();
      logic [7:0] q;
      int base, k;
      base = sent.size();
      stall = 1;
      @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         cs = 1; we = 1; rs = 1; din = 8'($urandom);
         if (txq.size() < 16) txq.push_back(din);
         @(negedge clk);
      end
      cs = 0; we = 0;
      access(0, 0, 8'h00, q);
      total++; if (q !== exp_stat(m_ovr, rxq.size(), txq.size(), 1)) begin bad++; $display("FAIL tx_full_status got=%h exp=%h", q, exp_stat(m_ovr, rxq.size(), txq.size(), 1)); end
      stall = 0;
      k = 0;
      while (sent.size() < base + 16 && k < 3000) begin @(negedge clk); k++; end
      repeat (60) @(negedge clk);
      total++; if (sent.size() != base + 16) begin bad++; $display("FAIL tx_full_count got=%0d exp=16", sent.size() - base); end
      for (int i = 0; i < 16 && base + i < sent.size(); i++) begin
         total++; if (sent[base+i] !== txq[i]) begin bad++; $display("FAIL tx_full_byte%0d got=%h exp=%h", i, sent[base+i], txq[i]); end
      end
      txq.delete();
      access(0, 0, 8'h00, q);
      total++; if (q !== exp_stat(m_ovr, rxq.size(), 0, 0)) begin bad++; $display("FAIL tx_full_idle got=%h exp=%h", q, exp_stat(m_ovr, rxq.size(), 0, 0)); end
   endtask

   task automatic test_flush();
      logic [7:0] q;
      int base;
      base = sent.size();
      stall = 1;
      for (int i = 0; i < 3; i++) begin access(1, 1, 8'($urandom), q); txq.push_back(din); end
      rx_pulse(8'($urandom)); rx_pulse(8'($urandom));
      access(0, 0, 8'h00, q);
      total++; if (q !== exp_stat(m_ovr, rxq.size(), txq.size(), 1)) begin bad++; $display("FAIL flush_pre got=%h exp=%h", q, exp_stat(m_ovr, rxq.size(), txq.size(), 1)); end
      access(1, 0, 8'h03, q);
      rxq.delete(); txq.delete(); m_ovr = 0;
      access(0, 0, 8'h00, q);
      total++; if (q !== exp_stat(0, 0, 0, 1)) begin bad++; $display("FAIL flush_post got=%h exp=%h", q, exp_stat(0, 0, 0, 1)); end
      stall = 0;
      repeat (60) @(negedge clk);
      total++; if (sent.size() != base) begin bad++; $display("FAIL flush_tx_sent got=%0d exp=0", sent.size() - base); end
      access(0, 1, 8'h00, q);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL flush_rx_read got=%h exp=00", q); end
   endtask

   task automatic test_rx_overrun();
      logic [7:0] q, e;
      for (int i = 0; i < 17; i++) rx_pulse(8'($urandom));
      access(0, 0, 8'h00, q);
      e = exp_stat(m_ovr, rxq.size(), 0, 0); m_ovr = 0;
      total++; if (q !== e) begin bad++; $display("FAIL ovr_status got=%h exp=%h", q, e); end
      access(0, 0, 8'h00, q);
      e = exp_stat(m_ovr, rxq.size(), 0, 0);
      total++; if (q !== e) begin bad++; $display("FAIL ovr_cleared got=%h exp=%h", q, e); end
      for (int i = 0; i < 16; i++) begin
         access(0, 1, 8'h00, q);
         e = rxq.pop_front();
         total++; if (q !== e) begin bad++; $display("FAIL ovr_read%0d got=%h exp=%h", i, q, e); end
      end
      access(0, 1, 8'h00, q);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL rx_empty_read got=%h exp=00", q); end
   endtask

   task automatic test_rx_same_cycle();
      logic [7:0] q, e, nb;
      access(1, 0, 8'h01, q);
      rxq.delete(); m_ovr = 0;
      for (int i = 0; i < 16; i++) rx_pulse(8'($urandom));
      nb = 8'($urandom);
      @(negedge clk); cs = 1; we = 0; rs = 1; rx_ready = 1; rx_byte = nb;
      @(negedge clk); cs = 0; rx_ready = 0; q = dout;
      e = rxq.pop_front(); rxq.push_back(nb);
      total++; if (q !== e) begin bad++; $display("FAIL same_cyc_head got=%h exp=%h", q, e); end
      access(0, 0, 8'h00, q);
      total++; if (q !== exp_stat(0, 16, 0, 0)) begin bad++; $display("FAIL same_cyc_status got=%h exp=%h", q, exp_stat(0, 16, 0, 0)); end
      for (int i = 0; i < 16; i++) begin
         access(0, 1, 8'h00, q);
         e = rxq.pop_front();
         total++; if (q !== e) begin bad++; $display("FAIL same_cyc_read%0d got=%h exp=%h", i, q, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic       pend, nr, rise;
      logic [7:0] pexp, q;
      int         act, rdp;
      pend = 0; pexp = 0;
      for (int c = 0; c < 240; c++) begin
         @(negedge clk);
         if (pend) begin
            total++; if (dout !== pexp) begin bad++; $display("FAIL mixed_rd cyc=%0d got=%h exp=%h", c, dout, pexp); end
         end
         nr = 1'($urandom); rise = nr & ~rx_ready;
         rx_ready = nr; rx_byte = 8'($urandom);
         rdp = (c < 120) ? 15 : 60;
         act = $urandom_range(0, 99);
         cs = 0; we = 0; pend = 0;
         if (act < rdp) begin
            cs = 1; rs = 1; pend = 1;
            pexp = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
         end else if (act < rdp + 10) begin
            cs = 1; rs = 0; pend = 1;
            pexp = exp_stat(m_ovr, rxq.size(), 0, 0);
         end
         if (rise) begin
            if (rxq.size() < 16) rxq.push_back(rx_byte);
            else m_ovr = 1;
         end else if (cs && !rs) m_ovr = 0;
      end
      @(negedge clk);
      if (pend) begin
         total++; if (dout !== pexp) begin bad++; $display("FAIL mixed_rd_last got=%h exp=%h", dout, pexp); end
      end
      cs = 0; rx_ready = 0;
      access(1, 0, 8'h01, q);
      rxq.delete(); m_ovr = 0;
   endtask

`ifdef UART_FIFO_IRQ_EN
   task automatic test_irq();
      logic [7:0] q;
      access(1, 0, 8'h04, q);
      rx_pulse(8'h5A);
      @(negedge clk);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
      access(0, 1, 8'h00, q);
      void'(rxq.pop_front());
      @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
      access(1, 0, 8'h00, q);
   endtask
`endif

   task automatic test_reset_mid_frame();
      logic [7:0] q;
      int k, base;
      access(0, 0, 8'h00, q);
      access(1, 1, 8'h3C, q);
      access(1, 1, 8'hC3, q);
      k = 0;
      while (tx_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL mid_start_seen got=%b exp=1", tx_start); end
      base = sent.size();
      #2 reset = 1;
      #1;
      total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b exp=0", tx_start); end
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL mid_dout got=%h exp=00", dout); end
      @(negedge clk); reset = 0;
      txq.delete(); rxq.delete(); m_ovr = 0;
      access(0, 0, 8'h00, q);
      total++; if (q !== exp_stat(0, 0, 0, 0)) begin bad++; $display("FAIL mid_status got=%h exp=%h", q, exp_stat(0, 0, 0, 0)); end
      repeat (80) @(negedge clk);
      total++; if (sent.size() != base) begin bad++; $display("FAIL mid_no_frame got=%0d exp=0", sent.size() - base); end
   endtask

   initial begin
      test_reset();
      test_tx_stream();
      test_tx_full();
      test_flush();
      test_rx_overrun();
      test_rx_same_cycle();
      test_back_to_back();
`ifdef UART_FIFO_IRQ_EN
      test_irq();
`endif
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
